dsp_sqrt_sched: RTL and testbench

Round-robin scheduler that shares one iterative square-root core (`int_sqrt_UAD`) between up to NREQ requesters, such as per-channel `dsp_SRC_power` meters. It latches the granted requester's 32-bit operand, pulses the core's start input, and counts the core's fixed latency. It then captures the 16-bit root and returns it with a one-cycle acknowledge tagged by requester index. It sits between the power-averaging stages and the single sqrt instance in the audio effector datapath.

---
 rtl/dsp_sqrt_sched.sv | 131 +++++++++++++
 tb/tb_dsp_sqrt_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_sqrt_sched.sv
// Round-robin share of one iterative sqrt core; optional DSP_SQRT_SCHED_ZERO_BYPASS_EN skips the core for 0.
// Latency LAT+3 cycles request-to-ack (2 with bypass); requests are levels held until their one-cycle oAck.
module dsp_sqrt_sched #(
    parameter int NREQ   = 4,
    parameter int LAT    = 17,
    parameter int CNT_WS = 5
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [NREQ-1:0]   iReq,
    input  logic [32*NREQ-1:0] iVal,
    output logic [NREQ-1:0]   oAck,
    output logic [15:0]       oRes,
    output logic [2:0]        oResId,
    output logic              oBusy,
    output logic [31:0]       oSQ_X,
    output logic              oSQ_START,
    input  logic [15:0]       iSQ_Y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [2:0]          id_q, id_d;
    logic [31:0]         x_q, x_d;
    logic [CNT_WS-1:0]   cnt_q, cnt_d;
    logic [15:0]         res_q, res_d;
    logic [2:0]          rid_q, rid_d;

    logic                gnt_vld;
    logic [2:0]          gnt_id;
    logic [31:0]         gnt_val;
    int                  k;

    // First pending request at or after ptr, wrapping around.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        gnt_val = '0;
        k       = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr_q) + i) % NREQ;
            if (!gnt_vld && iReq[k]) begin
                gnt_vld = 1'b1;
                gnt_id  = 3'(k);
                gnt_val = iVal[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rid_d   = rid_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    id_d = gnt_id;
                    x_d  = gnt_val;
`ifdef DSP_SQRT_SCHED_ZERO_BYPASS_EN
                    if (gnt_val == 32'd0) begin
                        res_d   = '0;
                        rid_d   = gnt_id;
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
`else
                    state_d = LOAD;
`endif
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_WS'(1);
                if (cnt_q == CNT_WS'(LAT - 1)) begin
                    res_d   = iSQ_Y;
                    rid_d   = id_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = (id_q == 3'(NREQ - 1)) ? 3'd0 : id_q + 3'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rid_q   <= rid_d;
        end
    end

    // Outputs decode directly from registered state so reset clears them at once.
    assign oAck      = (state_q == DONE) ? (NREQ'(1) << id_q) : '0;
    assign oRes      = res_q;
    assign oResId    = rid_q;
    assign oBusy     = (state_q != IDLE);
    assign oSQ_X     = x_q;
    assign oSQ_START = (state_q == LOAD);

endmodule

// File: tb/tb_dsp_sqrt_sched.sv
// Randomised self-checking bench for dsp_sqrt_sched with a behavioural sqrt core and reference model.
module tb_dsp_sqrt_sched;
    localparam int NREQ   = 4;
    localparam int LAT    = 17;
    localparam int CNT_WS = 5;

    logic              iCLK;
    logic              iRST_N;
    logic [NREQ-1:0]   iReq;
    logic [32*NREQ-1:0] iVal;
    logic [NREQ-1:0]   oAck;
    logic [15:0]       oRes;
    logic [2:0]        oResId;
    logic              oBusy;
    logic [31:0]       oSQ_X;
    logic              oSQ_START;
    logic [15:0]       iSQ_Y;

    int n_vec;
    int n_err;
    int model_ptr;

    dsp_sqrt_sched #(.NREQ(NREQ), .LAT(LAT), .CNT_WS(CNT_WS)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iReq(iReq), .iVal(iVal),
        .oAck(oAck), .oRes(oRes), .oResId(oResId), .oBusy(oBusy),
        .oSQ_X(oSQ_X), .oSQ_START(oSQ_START), .iSQ_Y(iSQ_Y)
    );

    always #5 iCLK = ~iCLK;

    // Behavioural core: bitwise root, output is junk until LAT cycles after the start cycle.
    function automatic logic [15:0] core_root(input logic [31:0] x);
        logic [63:0] r;
        logic [63:0] t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, x}) r = t;
        end
        return r[15:0];
    endfunction

    logic [31:0] core_x;
    int          core_cnt;
    initial begin
        core_x   = 0;
        core_cnt = 1000;
    end
    always @(posedge iCLK) begin
        if (oSQ_START) begin
            core_x   <= oSQ_X;
            core_cnt <= 0;
        end else if (core_cnt < 1000) begin
            core_cnt <= core_cnt + 1;
        end
    end
    assign iSQ_Y = (core_cnt >= LAT - 1) ? core_root(core_x) : (16'hDEAD ^ 16'(core_cnt));

    function automatic int ref_root(input longint v);
        return int'($floor($sqrt(real'(v))));
    endfunction

    function automatic int pick(input logic [NREQ-1:0] mask, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_val(input int id, input logic [31:0] v);
        iVal[32*id +: 32] = v;
    endtask

    task automatic wait_ack(output int ack_cyc, output int start_cyc, output logic [31:0] x_st,
                            output logic busy_ok, output logic [NREQ-1:0] ack_v,
                            output logic [15:0] res, output logic [2:0] rid);
        ack_cyc = -1; start_cyc = -1; x_st = 0; busy_ok = 1'b1; ack_v = 0; res = 0; rid = 0;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (oSQ_START && start_cyc < 0) begin
                start_cyc = c;
                x_st      = oSQ_X;
            end
            if (!oBusy) busy_ok = 1'b0;
            if (oAck != 0) begin
                ack_cyc = c; ack_v = oAck; res = oRes; rid = oResId;
                break;
            end
        end
    endtask

    task automatic reset_dut();
        iReq = 0;
        iRST_N = 0;
        tick();
        tick();
        iRST_N = 1;
        model_ptr = 0;
        tick();
    endtask

    task automatic test_reset();
        #2 iRST_N = 0;
        #1;
        n_vec++;
        if ({oAck, oRes, oResId, oBusy, oSQ_X, oSQ_START} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ack=%b res=%0d id=%0d busy=%b x=%0h start=%b required all zero",
                     oAck, oRes, oResId, oBusy, oSQ_X, oSQ_START);
        end
        tick();
        iRST_N = 1;
        model_ptr = 0;
        tick();
        n_vec++;
        if (oBusy !== 1'b0 || oAck !== '0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b ack=%b required 0 0", oBusy, oAck);
        end
    endtask

    task automatic test_single();
        int sc, ac; logic [31:0] xs; logic bok; logic [NREQ-1:0] av; logic [15:0] r; logic [2:0] id;
        set_val(0, 32'd49283);
        iReq = 4'b0001;
        wait_ack(ac, sc, xs, bok, av, r, id);
        n_vec += 7;
        if (sc !== 1) begin n_err++; $display("FAIL single_start_cyc: got %0d required 1", sc); end
        if (xs !== 32'd49283) begin n_err++; $display("FAIL single_sq_x: got %0d required 49283", xs); end
        if (ac !== LAT + 2) begin n_err++; $display("FAIL single_ack_cyc: got %0d required %0d", ac, LAT + 2); end
        if (av !== 4'b0001) begin n_err++; $display("FAIL single_ack_vec: got %b required 0001", av); end
        if (r !== 16'd221) begin n_err++; $display("FAIL single_res: got %0d required 221", r); end
        if (id !== 3'd0) begin n_err++; $display("FAIL single_id: got %0d required 0", id); end
        if (bok !== 1'b1) begin n_err++; $display("FAIL single_busy: got dropout required busy held"); end
        iReq = 0;
        model_ptr = 1;
        tick();
        n_vec++;
        if (oBusy !== 1'b0 || oAck !== '0 || oRes !== 16'd221) begin
            n_err++;
            $display("FAIL single_after: got busy=%b ack=%b res=%0d required 0 0 221", oBusy, oAck, oRes);
        end
    endtask

    task automatic test_full_scale();
        int ids[3] = '{2, 1, 3};
        logic [31:0] vals[3] = '{32'd4294574099, 32'd3224990521, 32'hFFFFFFFF};
        int exps[3] = '{65533, 56789, 65535};
        int sc, ac; logic [31:0] xs; logic bok; logic [NREQ-1:0] av; logic [15:0] r; logic [2:0] id;
        for (int t = 0; t < 3; t++) begin
            set_val(ids[t], vals[t]);
            iReq = NREQ'(1) << ids[t];
            wait_ack(ac, sc, xs, bok, av, r, id);
            n_vec += 3;
            if (ac !== LAT + 2) begin n_err++; $display("FAIL full_ack_cyc[%0d]: got %0d required %0d", t, ac, LAT + 2); end
            if (r !== 16'(exps[t])) begin n_err++; $display("FAIL full_res[%0d]: got %0d required %0d", t, r, exps[t]); end
            if (id !== 3'(ids[t])) begin n_err++; $display("FAIL full_id[%0d]: got %0d required %0d", t, id, ids[t]); end
            iReq = 0;
            model_ptr = (ids[t] + 1) % NREQ;
            tick();
        end
    endtask

    task automatic test_rr_pointer();
        int sc, ac; logic [31:0] xs; logic bok; logic [NREQ-1:0] av; logic [15:0] r; logic [2:0] id;
        set_val(2, $urandom);
        iReq = 4'b0100;
        wait_ack(ac, sc, xs, bok, av, r, id);
        n_vec++;
        if (id !== 3'd2) begin n_err++; $display("FAIL rr_first_id: got %0d required 2", id); end
        iReq = 0;
        tick();
        set_val(0, $urandom_range(1, 32'hFFFF_FFFF));
        set_val(3, $urandom_range(1, 32'hFFFF_FFFF));
        iReq = 4'b1001;
        wait_ack(ac, sc, xs, bok, av, r, id);
        n_vec += 3;
        if (id !== 3'd3) begin n_err++; $display("FAIL rr_id3: got %0d required 3", id); end
        if (av !== 4'b1000) begin n_err++; $display("FAIL rr_ack3: got %b required 1000", av); end
        if (r !== 16'(ref_root(longint'(iVal[96 +: 32])))) begin
            n_err++; $display("FAIL rr_res3: got %0d required %0d", r, ref_root(longint'(iVal[96 +: 32])));
        end
        iReq = 4'b0001;
        wait_ack(ac, sc, xs, bok, av, r, id);
        n_vec += 2;
        if (id !== 3'd0) begin n_err++; $display("FAIL rr_id0: got %0d required 0", id); end
        if (ac !== LAT + 3) begin n_err++; $display("FAIL rr_gap: got %0d required %0d", ac, LAT + 3); end
        iReq = 0;
        model_ptr = 1;
        tick();
    endtask

    task automatic test_fairness();
        int sc, ac; logic [31:0] xs; logic bok; logic [NREQ-1:0] av; logic [15:0] r; logic [2:0] id;
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_val(i, $urandom_range(1, 32'hFFFF_FFFF));
        iReq = '1;
        for (int n = 0; n < 5; n++) begin
            wait_ack(ac, sc, xs, bok, av, r, id);
            n_vec += 3;
            if (id !== 3'(n % NREQ)) begin n_err++; $display("FAIL fair_id[%0d]: got %0d required %0d", n, id, n % NREQ); end
            if (ac !== ((n == 0) ? LAT + 2 : LAT + 3)) begin
                n_err++; $display("FAIL fair_spacing[%0d]: got %0d required %0d", n, ac, (n == 0) ? LAT + 2 : LAT + 3);
            end
            if (r !== 16'(ref_root(longint'(iVal[32*(n % NREQ) +: 32])))) begin
                n_err++; $display("FAIL fair_res[%0d]: got %0d required %0d", n, r, ref_root(longint'(iVal[32*(n % NREQ) +: 32])));
            end
        end
        iReq = 0;
        model_ptr = 1;
        tick();
    endtask

    task automatic test_random();
        int sc, ac, eid; logic [31:0] xs; logic bok; logic [NREQ-1:0] av; logic [15:0] r; logic [2:0] id;
        logic [NREQ-1:0] mask;
        logic [31:0] v;
        bit first;
        for (int round = 0; round < 12; round++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 3))
                    0: v = 32'hFFFF_FFFF;
                    1: begin v = $urandom_range(1, 65535); v = v * v; end
                    default: v = $urandom_range(1, 32'hFFFF_FFFF);
                endcase
                set_val(i, v);
            end
            iReq = mask;
            first = 1'b1;
            while (mask != 0) begin
                eid = pick(mask, model_ptr);
                wait_ack(ac, sc, xs, bok, av, r, id);
                n_vec += 4;
                if (id !== 3'(eid)) begin n_err++; $display("FAIL rand_id[%0d]: got %0d required %0d", round, id, eid); end
                if (av !== NREQ'(1) << eid) begin n_err++; $display("FAIL rand_ack[%0d]: got %b required id %0d", round, av, eid); end
                if (r !== 16'(ref_root(longint'(iVal[32*eid +: 32])))) begin
                    n_err++; $display("FAIL rand_res[%0d]: got %0d required %0d", round, r, ref_root(longint'(iVal[32*eid +: 32])));
                end
                if (ac !== (first ? LAT + 2 : LAT + 3)) begin
                    n_err++; $display("FAIL rand_cyc[%0d]: got %0d required %0d", round, ac, first ? LAT + 2 : LAT + 3);
                end
                mask[eid] = 1'b0;
                iReq = mask;
                model_ptr = (eid + 1) % NREQ;
                first = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_busy();
        int sc, ac; logic [31:0] xs; logic bok; logic [NREQ-1:0] av; logic [15:0] r; logic [2:0] id;
        bit saw_ack;
        set_val(1, $urandom_range(1, 32'hFFFF_FFFF));
        iReq = 4'b0010;
        for (int c = 0; c < 10; c++) tick();
        n_vec++;
        if (oBusy !== 1'b1) begin n_err++; $display("FAIL rst_busy_before: got %b required 1", oBusy); end
        iRST_N = 0;
        #1;
        n_vec++;
        if ({oAck, oRes, oResId, oBusy, oSQ_X, oSQ_START} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got ack=%b res=%0d id=%0d busy=%b x=%0h start=%b required all zero",
                     oAck, oRes, oResId, oBusy, oSQ_X, oSQ_START);
        end
        saw_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (oAck !== '0) saw_ack = 1'b1;
        end
        n_vec++;
        if (saw_ack) begin n_err++; $display("FAIL rst_no_ack: got ack during reset required none"); end
        iRST_N = 1;
        model_ptr = 0;
        wait_ack(ac, sc, xs, bok, av, r, id);
        n_vec += 4;
        if (sc !== 1) begin n_err++; $display("FAIL rst_refresh_start: got %0d required 1", sc); end
        if (ac !== LAT + 2) begin n_err++; $display("FAIL rst_refresh_cyc: got %0d required %0d", ac, LAT + 2); end
        if (id !== 3'd1) begin n_err++; $display("FAIL rst_refresh_id: got %0d required 1", id); end
        if (r !== 16'(ref_root(longint'(iVal[32 +: 32])))) begin
            n_err++; $display("FAIL rst_refresh_res: got %0d required %0d", r, ref_root(longint'(iVal[32 +: 32])));
        end
        iReq = 0;
        model_ptr = 2;
        tick();
    endtask

    task automatic test_zero();
        int sc, ac; logic [31:0] xs; logic bok; logic [NREQ-1:0] av; logic [15:0] r; logic [2:0] id;
        set_val(2, 32'd1000000);
        iReq = 4'b0100;
        wait_ack(ac, sc, xs, bok, av, r, id);
        iReq = 0;
        tick();
        set_val(1, 32'd0);
        iReq = 4'b0010;
        wait_ack(ac, sc, xs, bok, av, r, id);
        n_vec += 5;
`ifdef DSP_SQRT_SCHED_ZERO_BYPASS_EN
        if (ac !== 1) begin n_err++; $display("FAIL zero_ack_cyc: got %0d required 1", ac); end
        if (sc !== -1) begin n_err++; $display("FAIL zero_start: got start at %0d required none", sc); end
`else
        if (ac !== LAT + 2) begin n_err++; $display("FAIL zero_ack_cyc: got %0d required %0d", ac, LAT + 2); end
        if (sc !== 1) begin n_err++; $display("FAIL zero_start: got %0d required 1", sc); end
`endif
        if (r !== 16'd0) begin n_err++; $display("FAIL zero_res: got %0d required 0", r); end
        if (id !== 3'd1) begin n_err++; $display("FAIL zero_id: got %0d required 1", id); end
        if (av !== 4'b0010) begin n_err++; $display("FAIL zero_ack_vec: got %b required 0010", av); end
        iReq = 0;
        tick();
    endtask

    initial begin
        iCLK = 0;
        iRST_N = 1;
        iReq = 0;
        iVal = 0;
        n_vec = 0;
        n_err = 0;
        model_ptr = 0;
        test_reset();
        test_single();
        test_full_scale();
        test_rr_pointer();
        test_fairness();
        test_random();
        test_reset_mid_busy();
        test_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
